ntt_naive_seq: RTL and testbench



---
 rtl/ntt_pkg.sv | 6 +
 rtl/mod_mul.sv | 13 +
 rtl/ntt_naive_seq.sv | 114 +++++++++++
 tb/tb_ntt_naive_seq.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// ntt_pkg: shared state encoding and mode constants for the naive NTT block
package ntt_pkg;
  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE, DRAIN} state_t;
  localparam logic MODE_FWD = 1'b0;
  localparam logic MODE_INV = 1'b1;
endpackage

// File: rtl/mod_mul.sv
// mod_mul: combinational (a*b) mod q with a full 2W-bit product
module mod_mul #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] q,
  output logic [W-1:0] p
);
  logic [2*W-1:0] prod;
  assign prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
  assign p = W'(prod % {{W{1'b0}}, q});
endmodule

// File: rtl/ntt_naive_seq.sv
// ntt_naive_seq: streaming O(N^2) forward/inverse NTT, one modular MAC per cycle
module ntt_naive_seq
  import ntt_pkg::*;
#(
  parameter int N    = 8,
  parameter int W    = 8,
  parameter int LOGN = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         mode,
  input  logic [W-1:0] omega,
  input  logic [W-1:0] omega_inv,
  input  logic [W-1:0] n_inv,
  input  logic [W-1:0] mod,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         busy,
  output logic         done,
  output logic         err
);
  localparam logic [LOGN-1:0] LAST = LOGN'(N - 1);
  state_t st, nxt;
  logic md, fin, hs_in, hs_out;
  logic [W-1:0] q, root, ninv, r, t, acc, xt, tr, rr, sc, acc_nxt, xin;
  logic [W-1:0] x [N];
  logic [W-1:0] ybuf [N];
  logic [LOGN-1:0] i, j, k;
  logic [2*W:0] sum;
  assign in_ready  = st == LOAD;
  assign out_valid = st == DRAIN;
  assign busy      = st != IDLE;
  assign out_data  = out_valid ? ybuf[k] : '0;
  assign hs_in     = in_valid & in_ready;
  assign hs_out    = out_valid & out_ready;
  assign xin       = in_data % q;
  assign sum       = (2*W+1)'(acc) + (2*W+1)'(xt);
  assign acc_nxt   = W'(sum % (2*W+1)'(q));
  mod_mul #(.W(W)) u_xt (.a(x[j]), .b(t),    .q(q), .p(xt));
  mod_mul #(.W(W)) u_tr (.a(t),    .b(r),    .q(q), .p(tr));
  mod_mul #(.W(W)) u_rr (.a(r),    .b(root), .q(q), .p(rr));
  mod_mul #(.W(W)) u_sc (.a(acc),  .b(ninv), .q(q), .p(sc));
  // state register
  always_ff @(posedge clk) st <= !rst_n ? IDLE : nxt;
  // next-state: each phase ends on its last index
  always_comb begin
    nxt = st;
    case (st)
      IDLE:    nxt = (start && mod > W'(1)) ? LOAD : IDLE;
      LOAD:    nxt = (hs_in && j == LAST) ? COMPUTE : LOAD;
      COMPUTE: nxt = (fin && i == LAST) ? DRAIN : COMPUTE;
      DRAIN:   nxt = (hs_out && k == LAST) ? IDLE : DRAIN;
      default: nxt = IDLE;
    endcase
  end
  // datapath: latch parameters, load x, N MAC cycles plus one finish cycle per row, drain ybuf
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      i <= '0;
      j <= '0;
      k <= '0;
      fin <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      done <= 1'b0;
      err <= 1'b0;
      case (st)
        IDLE: if (start) begin
          err <= mod < W'(2);
          md <= mode;
          q <= mod;
          root <= mode == MODE_INV ? omega_inv : omega;
          ninv <= n_inv;
          i <= '0;
          j <= '0;
          k <= '0;
        end
        LOAD: if (hs_in) begin
          x[j] <= xin;
          j <= j + 1'b1;
          i <= '0;
          r <= W'(1);
          t <= W'(1);
          acc <= '0;
          fin <= 1'b0;
        end
        COMPUTE: if (!fin) begin
          acc <= acc_nxt;
          t <= tr;
          j <= j + 1'b1;
          fin <= j == LAST;
        end else begin
          ybuf[i] <= md == MODE_INV ? sc : acc;
          r <= rr;
          i <= i + 1'b1;
          t <= W'(1);
          acc <= '0;
          fin <= 1'b0;
        end
        DRAIN: begin
          if (hs_out) k <= k + 1'b1;
          done <= hs_out && k == LAST;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_ntt_naive_seq.sv
// tb_ntt_naive_seq: directed vectors with hand-computed results for ntt_naive_seq
module tb_ntt_naive_seq;
  localparam int N = 8;
  localparam int W = 8;
  logic clk = 0, rst_n = 0, start = 0, mode = 0, in_valid = 0, out_ready = 0;
  logic [W-1:0] omega = 2, omega_inv = 9, n_inv = 15, mod = 17, in_data = 0;
  logic in_ready, out_valid, busy, done, err;
  logic [W-1:0] out_data;
  int checks = 0, failures = 0, cyc = 0;
  logic [W-1:0] vin [N];
  logic [W-1:0] vout [N];
  logic [W-1:0] vexp [N];
  logic [W-1:0] orig [N];

  ntt_naive_seq #(.N(N), .W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .omega(omega),
    .omega_inv(omega_inv), .n_inv(n_inv), .mod(mod), .in_valid(in_valid),
    .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic m);
    start = 1;
    mode = m;
    step;
    start = 0;
    chk("start_busy", busy, 1);
    chk("start_err", err, 0);
  endtask

  task automatic feed(input bit gaps, output int hs);
    hs = 0;
    for (int j = 0; j < N; j++) begin
      if (gaps && $urandom_range(0, 1) == 1) begin
        in_valid = 0;
        step;
      end
      in_valid = 1;
      in_data = vin[j];
      for (int b = 0; b < 100 && !in_ready; b++) step;
      if (!in_ready) chk("in_ready_timeout", 0, 1);
      hs = cyc;
      step;
    end
    in_valid = 0;
  endtask

  task automatic drain(input bit stall, output int ov);
    logic [W-1:0] hold;
    for (int b = 0; b < 200 && !out_valid; b++) step;
    if (!out_valid) chk("out_valid_timeout", 0, 1);
    ov = cyc;
    for (int k = 0; k < N; k++) begin
      if (stall && k == 3) begin
        out_ready = 0;
        hold = out_data;
        for (int s = 0; s < 5; s++) begin
          step;
          chk("stall_data", out_data, hold);
          chk("stall_valid", out_valid, 1);
        end
      end
      out_ready = 1;
      for (int b = 0; b < 50 && !out_valid; b++) step;
      vout[k] = out_data;
      chk("done_early", done, 0);
      step;
    end
    out_ready = 0;
    chk("done_pulse", done, 1);
    chk("busy_after", busy, 0);
    step;
    chk("done_once", done, 0);
  endtask

  task automatic run(input logic m, input bit gaps, input bit stall);
    int hs, ov;
    go(m);
    feed(gaps, hs);
    drain(stall, ov);
    chk("latency", ov - hs, N * (N + 1) + 1);
  endtask

  task automatic compare(input string tag);
    for (int k = 0; k < N; k++) chk($sformatf("%s[%0d]", tag, k), vout[k], vexp[k]);
  endtask

  initial begin
    int hs, ov;
    repeat (3) step;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    rst_n = 1;
    step;

    vin = '{1, 0, 0, 0, 0, 0, 0, 0};
    vexp = '{1, 1, 1, 1, 1, 1, 1, 1};
    run(0, 0, 0);
    compare("fwd_delta");

    vin = '{0, 1, 0, 0, 0, 0, 0, 0};
    vexp = '{1, 2, 4, 8, 16, 15, 13, 9};
    run(0, 0, 0);
    compare("fwd_e1");

    vin = '{1, 1, 1, 1, 1, 1, 1, 1};
    vexp = '{8, 0, 0, 0, 0, 0, 0, 0};
    run(0, 0, 0);
    compare("fwd_ones");

    vin = '{8, 0, 0, 0, 0, 0, 0, 0};
    vexp = '{1, 1, 1, 1, 1, 1, 1, 1};
    run(1, 0, 0);
    compare("inv_eight");

    vin = '{1, 1, 1, 1, 1, 1, 1, 1};
    vexp = '{1, 0, 0, 0, 0, 0, 0, 0};
    run(1, 0, 0);
    compare("inv_ones");

    vin = '{3, 16, 0, 7, 11, 5, 9, 20};
    vexp = '{3, 16, 0, 7, 11, 5, 9, 3};
    run(0, 0, 0);
    vin = vout;
    run(1, 0, 0);
    compare("round_trip");

    orig = '{5, 12, 1, 14, 2, 8, 13, 6};
    vin = orig;
    run(0, 1, 1);
    vin = vout;
    run(1, 1, 1);
    vexp = orig;
    compare("bp_round_trip");

    vin = '{1, 1, 1, 1, 1, 1, 1, 1};
    go(0);
    feed(0, hs);
    repeat (3 * (N + 1) + 2) step;
    chk("abort_pre_busy", busy, 1);
    rst_n = 0;
    step;
    rst_n = 1;
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", in_ready, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_done", done, 0);
    for (int c = 0; c < 4; c++) begin
      step;
      chk("abort_no_done", done, 0);
      chk("abort_idle", busy, 0);
    end
    vexp = '{8, 0, 0, 0, 0, 0, 0, 0};
    run(0, 0, 0);
    compare("after_abort");

    mod = 1;
    start = 1;
    step;
    start = 0;
    chk("bad_mod_err", err, 1);
    chk("bad_mod_busy", busy, 0);
    step;
    chk("bad_mod_err_once", err, 0);
    chk("bad_mod_idle", busy, 0);
    mod = 17;

    vin = '{0, 1, 0, 0, 0, 0, 0, 0};
    vexp = '{1, 2, 4, 8, 16, 15, 13, 9};
    go(0);
    feed(0, hs);
    repeat (10) step;
    start = 1;
    mode = 1;
    omega = 5;
    step;
    start = 0;
    mode = 0;
    omega = 2;
    chk("busy_start_err", err, 0);
    drain(0, ov);
    chk("busy_start_latency", ov - hs, N * (N + 1) + 1);
    compare("busy_start");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
